async_signal_sync: RTL and testbench
====================================

Name: async_signal_sync

Overview:
- Parametrised multi-channel synchroniser for asynchronous level inputs such as interrupt lines, debug requests and cross-domain valid/ack toggles.
- Each channel has a DEPTH-stage synchroniser chain, an optional glitch filter (debounce) and an edge detector.
- Per-channel outputs: a clean level, plus one-cycle rise, fall and toggle pulses.
- Placed at the receiving-domain boundary; replaces single-bit, fixed-depth valid synchronisers.

Parameters:
CHANNELS, 4, number of independent 1-bit channels (1..64)
DEPTH, 3, synchroniser flop stages per channel (2..8)
FILTER, 0, debounce length in cycles; 0 = filter bypassed (0..255)
INIT, 0, CHANNELS-bit reset value of every per-channel state element (sync stages, filter state, edge history)

Ports:
clock  in  1  receiving-domain clock
reset  in  1  synchronous active-high reset
io_in  in  CHANNELS  asynchronous inputs, bit i = channel i
io_out  out  CHANNELS  synchronised, filtered level
io_rise  out  CHANNELS  1-cycle pulse when io_out[i] goes 0->1
io_fall  out  CHANNELS  1-cycle pulse when io_out[i] goes 1->0
io_toggle  out  CHANNELS  io_rise | io_fall; used for toggle-encoded handshakes
io_filter_busy  out  1  OR over channels of "filter counter nonzero"; constant 0 when FILTER=0

Behaviour:
- Interface (decided): one clock, port `clock`; reset port `reset`, synchronous, active-high; no other clocks or resets.
- Reset (sync, active-high): on any edge with reset=1:
  - all sync stages, filter state and edge-history flops load INIT[i];
  - filter counters load 0.
- Outputs while reset is held and in the first cycle after release:
  - io_out = INIT;
  - io_rise, io_fall, io_toggle = 0;
  - io_filter_busy = 0.
- Synchroniser:
  - sync[0][i] <= io_in[i]; sync[k] <= sync[k-1] for k = 1..DEPTH-1;
  - s[i] = sync[DEPTH-1][i];
  - no logic between stages; each chain bit is an independent flop.
- FILTER=0: io_out = s, taken directly from the last stage.
  - Latency: an io_in change sampled at edge t is visible on io_out after edge t+DEPTH-1 (DEPTH edges including t).
- FILTER>0: per-channel state f[i] and counter c[i], counter width clog2(FILTER+1). Each cycle:
  - s[i]==f[i]: c[i] <= 0.
  - s[i]!=f[i] and c[i]==FILTER-1: f[i] <= s[i], c[i] <= 0.
  - otherwise: c[i] <= c[i]+1.
  - io_out = f.
- Filter consequences:
  - s must differ from f for FILTER consecutive cycles before io_out changes;
  - a shorter excursion is discarded and the counter clears when s returns;
  - latency = DEPTH + FILTER edges;
  - FILTER=1 adds exactly one cycle and no rejection.
- Edge detector:
  - h[i] <= io_out[i] every cycle;
  - io_rise = io_out & ~h; io_fall = ~io_out & h; io_toggle = io_out ^ h.
  - Pulses are combinational from flops, asserted in the first cycle io_out shows the new value, and last exactly one cycle.
  - Rise and fall are never both high on one channel.
- Channels are fully independent; simultaneous changes on several channels produce simultaneous pulses.
- Reset mid-operation:
  - in-flight values in chains and counters are discarded;
  - no pulse is generated by the reset-induced change of io_out;
  - h loads INIT in the same edge.
- Input toggling every cycle with FILTER=0: io_out follows with DEPTH-cycle delay and a pulse every cycle (no loss; metastability aside).
- Widths:
  - counters saturate logically at FILTER-1 and never wrap;
  - for illegal parameter values (DEPTH<2, FILTER>255), elaboration fails via an assertion.

Test Plan:
1. CHANNELS=4, DEPTH=3, FILTER=0, INIT=0: io_in[0] 0->1 before edge 10 -> io_out[0]=1 after edge 12; io_rise[0]=1 for exactly that one cycle; io_toggle[0]=1 in the same cycle; other channels stay 0.
2. Same config, io_in=4'b1010 held, then 4'b0101 -> two cycles later io_fall=4'b1010 and io_rise=4'b0101 in the same cycle, each for one cycle.
3. FILTER=4, DEPTH=2: 3-cycle high glitch on io_in[1] -> io_out[1] stays 0, no pulses, io_filter_busy high for 3 cycles. A 4-cycle-wide high -> io_out[1]=1 six edges after first sample, one rise pulse.
4. INIT=4'b1111, DEPTH=3: reset held 5 cycles with io_in=0 -> io_out=4'b1111 and no pulses during and one cycle after reset. io_fall=4'b1111 appears once, 3 edges after release.
5. Reset asserted 1 cycle before a pending io_out[2] change (FILTER=0) -> change discarded, io_out=INIT, no pulse. After release the still-present input propagates with full DEPTH latency.
6. FILTER=0, io_in[3] toggled every cycle for 20 cycles -> io_toggle[3]=1 on 20 consecutive cycles starting DEPTH edges after the first toggle; io_rise[3] and io_fall[3] alternate and are never both high.

Source files
------------

// File: rtl/async_signal_sync.sv
// async_signal_sync: multi-channel level synchroniser with an
// optional debounce filter and rise/fall/toggle pulse outputs.
module async_signal_sync #(
  parameter int                  CHANNELS = 4,
  parameter int                  DEPTH    = 3,
  parameter int                  FILTER   = 0,
  parameter logic [CHANNELS-1:0] INIT     = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] io_in,
  output logic [CHANNELS-1:0] io_out,
  output logic [CHANNELS-1:0] io_rise,
  output logic [CHANNELS-1:0] io_fall,
  output logic [CHANNELS-1:0] io_toggle,
  output logic                io_filter_busy
);

  localparam int CW = (FILTER > 0) ? $clog2(FILTER + 1) : 1;

  if (CHANNELS < 1 || CHANNELS > 64) begin : g_bad_channels
    $error("async_signal_sync: CHANNELS must be 1..64");
  end
  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("async_signal_sync: DEPTH must be 2..8");
  end
  if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
    $error("async_signal_sync: FILTER must be 0..255");
  end

  logic [CHANNELS-1:0] sync_q [DEPTH];
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] lvl;
  logic [CHANNELS-1:0] hist_q;

  // plain flop chain, no logic between stages
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        sync_q[k] <= INIT;
      end
    end else begin
      sync_q[0] <= io_in;
      for (int k = 1; k < DEPTH; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[DEPTH-1];

  if (FILTER == 0) begin : g_nofilt
    assign lvl            = s;
    assign io_filter_busy = 1'b0;
  end else begin : g_filt
    localparam logic [CW-1:0] LAST = CW'(FILTER - 1);

    logic [CHANNELS-1:0] f_q;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CHANNELS-1:0] busy;

    // accept a new level only after FILTER steady cycles
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < CHANNELS; i++) begin
          f_q[i]   <= INIT[i];
          cnt_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (s[i] == f_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == LAST) begin
            f_q[i]   <= s[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end
      end
    end

    // a channel is busy while its excursion counter runs
    always_comb begin
      busy = '0;
      for (int i = 0; i < CHANNELS; i++) begin
        busy[i] = |cnt_q[i];
      end
    end

    assign lvl            = f_q;
    assign io_filter_busy = |busy;
  end

  // previous output level for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= INIT;
    end else begin
      hist_q <= lvl;
    end
  end

  assign io_out    = lvl;
  assign io_rise   = lvl & ~hist_q;
  assign io_fall   = ~lvl & hist_q;
  assign io_toggle = lvl ^ hist_q;

endmodule

// File: tb/tb_async_signal_sync.sv
// tb_async_signal_sync: four configurations of the synchroniser
// checked against a sliding-window model plus directed literals.
module tb_async_signal_sync;

  localparam int NI = 4;
  localparam int HM = 2048;
  localparam int DP [NI] = '{3, 2, 3, 3};
  localparam int FL [NI] = '{0, 4, 0, 1};
  localparam logic [3:0] IV [NI] = '{4'h0, 4'h0, 4'hF, 4'h5};

  logic       clock = 1'b0;
  logic [3:0] din [NI];
  logic       rst [NI];
  logic [3:0] q  [NI];
  logic [3:0] ri [NI];
  logic [3:0] fa [NI];
  logic [3:0] tg [NI];
  logic       bz [NI];

  int tests = 0;
  int fails = 0;
  int n = 0;

  logic [3:0] hin [NI][HM];
  bit         hr  [NI][HM];
  logic [3:0] hs  [NI][HM];
  logic [3:0] hf  [NI][HM];

  always #5 clock = ~clock;

  async_signal_sync #(.CHANNELS(4), .DEPTH(3), .FILTER(0),
    .INIT(4'h0)) u_a (
    .clock(clock), .reset(rst[0]), .io_in(din[0]),
    .io_out(q[0]), .io_rise(ri[0]), .io_fall(fa[0]),
    .io_toggle(tg[0]), .io_filter_busy(bz[0]));

  async_signal_sync #(.CHANNELS(4), .DEPTH(2), .FILTER(4),
    .INIT(4'h0)) u_b (
    .clock(clock), .reset(rst[1]), .io_in(din[1]),
    .io_out(q[1]), .io_rise(ri[1]), .io_fall(fa[1]),
    .io_toggle(tg[1]), .io_filter_busy(bz[1]));

  async_signal_sync #(.CHANNELS(4), .DEPTH(3), .FILTER(0),
    .INIT(4'hF)) u_c (
    .clock(clock), .reset(rst[2]), .io_in(din[2]),
    .io_out(q[2]), .io_rise(ri[2]), .io_fall(fa[2]),
    .io_toggle(tg[2]), .io_filter_busy(bz[2]));

  async_signal_sync #(.CHANNELS(4), .DEPTH(3), .FILTER(1),
    .INIT(4'h5)) u_d (
    .clock(clock), .reset(rst[3]), .io_in(din[3]),
    .io_out(q[3]), .io_rise(ri[3]), .io_fall(fa[3]),
    .io_toggle(tg[3]), .io_filter_busy(bz[3]));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit rst_at(int k, int t);
    if (t < 0) return 1'b1;
    return hr[k][t];
  endfunction

  function automatic logic [3:0] f_prev(int k, int t);
    if (t < 0) return IV[k];
    return hf[k][t];
  endfunction

  // s after edge t: input sampled DEPTH-1 edges earlier,
  // or INIT if any reset hit the last DEPTH edges
  function automatic logic [3:0] s_at(int k, int t);
    for (int e = t - DP[k] + 1; e <= t; e++) begin
      if (rst_at(k, e)) return IV[k];
    end
    return hin[k][t-DP[k]+1];
  endfunction

  // level flips once s disagreed for FILTER reset-free cycles
  function automatic logic [3:0] f_at(int k, int t);
    logic [3:0] fp;
    logic [3:0] r;
    bit ok;
    if (rst_at(k, t)) return IV[k];
    if (FL[k] == 0) return hs[k][t];
    fp = f_prev(k, t - 1);
    r = fp;
    for (int b = 0; b < 4; b++) begin
      ok = 1'b1;
      for (int e = t - FL[k] + 1; e <= t; e++) begin
        if (rst_at(k, e)) ok = 1'b0;
      end
      for (int j = t - FL[k]; j < t; j++) begin
        if (j < 0) ok = 1'b0;
        else if (hs[k][j][b] == fp[b]) ok = 1'b0;
      end
      if (ok) r[b] = ~fp[b];
    end
    return r;
  endfunction

  initial begin
    logic [3:0] eo, eh, sp, fp;
    logic       eb;
    forever begin
      @(posedge clock);
      if (n < HM) begin
        for (int k = 0; k < NI; k++) begin
          hin[k][n] = din[k];
          hr[k][n]  = rst[k];
          hs[k][n]  = s_at(k, n);
          hf[k][n]  = f_at(k, n);
        end
        #1;
        for (int k = 0; k < NI; k++) begin
          eo = hf[k][n];
          fp = f_prev(k, n - 1);
          eh = rst_at(k, n) ? IV[k] : fp;
          sp = (n > 0) ? hs[k][n-1] : IV[k];
          eb = (FL[k] > 0) && !rst_at(k, n) &&
               (|((sp ^ fp) & ~(eo ^ fp)));
          chk($sformatf("m%0d out c%0d", k, n), 32'(q[k]), 32'(eo));
          chk($sformatf("m%0d rise c%0d", k, n), 32'(ri[k]),
              32'(eo & ~eh));
          chk($sformatf("m%0d fall c%0d", k, n), 32'(fa[k]),
              32'(~eo & eh));
          chk($sformatf("m%0d tog c%0d", k, n), 32'(tg[k]),
              32'(eo ^ eh));
          chk($sformatf("m%0d busy c%0d", k, n), 32'(bz[k]),
              32'(eb));
        end
        n++;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    int c0, c1, c2, first, last;
    bit both;
    for (int k = 0; k < NI; k++) begin
      din[k] = 4'h0;
      rst[k] = 1'b1;
    end

    // reset held 5 cycles, INIT=F with zero inputs
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst C out", 32'(q[2]), 32'hF);
      chk("rst C tog", 32'(tg[2]), 32'h0);
    end
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    tick();
    chk("rel1 C out", 32'(q[2]), 32'hF);
    chk("rel1 C fall", 32'(fa[2]), 32'h0);
    tick();
    chk("rel2 C fall", 32'(fa[2]), 32'h0);
    tick();
    chk("rel3 C fall", 32'(fa[2]), 32'hF);
    chk("rel3 C out", 32'(q[2]), 32'h0);
    chk("rel3 D out", 32'(q[3]), 32'h5);
    tick();
    chk("rel4 C fall", 32'(fa[2]), 32'h0);
    chk("rel4 D fall", 32'(fa[3]), 32'h5);
    chk("rel4 D out", 32'(q[3]), 32'h0);
    repeat (2) tick();

    // single rise on channel 0
    din[0] = 4'b0001;
    tick();
    chk("t1 e0 out", 32'(q[0]), 32'h0);
    tick();
    chk("t1 e1 out", 32'(q[0]), 32'h0);
    tick();
    chk("t1 e2 out", 32'(q[0]), 32'h1);
    chk("t1 e2 rise", 32'(ri[0]), 32'h1);
    chk("t1 e2 tog", 32'(tg[0]), 32'h1);
    tick();
    chk("t1 e3 rise", 32'(ri[0]), 32'h0);
    chk("t1 e3 out", 32'(q[0]), 32'h1);
    din[0] = 4'h0;
    repeat (4) tick();

    // simultaneous rise and fall on different channels
    din[0] = 4'b1010;
    repeat (4) tick();
    din[0] = 4'b0101;
    tick();
    tick();
    chk("t2 e1 fall", 32'(fa[0]), 32'h0);
    tick();
    chk("t2 e2 fall", 32'(fa[0]), 32'hA);
    chk("t2 e2 rise", 32'(ri[0]), 32'h5);
    tick();
    chk("t2 e3 tog", 32'(tg[0]), 32'h0);
    din[0] = 4'h0;
    repeat (4) tick();

    // 3-cycle glitch through a 4-cycle filter is rejected
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 11; i++) begin
      din[1] = (i < 3) ? 4'b0010 : 4'b0000;
      tick();
      c0 += int'(bz[1]);
      c1 += int'(q[1][1]);
      c2 += int'(tg[1][1]);
    end
    chk("t3 busy cycles", 32'(c0), 32'd3);
    chk("t3 glitch out", 32'(c1), 32'd0);
    chk("t3 glitch pulses", 32'(c2), 32'd0);

    // 4-cycle pulse passes, 6 edges latency
    c0 = 0;
    for (int i = 0; i < 14; i++) begin
      din[1] = (i < 4) ? 4'b0010 : 4'b0000;
      tick();
      if (i == 4) chk("t3 e4 out", 32'(q[1][1]), 32'd0);
      if (i == 5) begin
        chk("t3 e5 out", 32'(q[1][1]), 32'd1);
        chk("t3 e5 rise", 32'(ri[1][1]), 32'd1);
      end
      c0 += int'(ri[1][1]);
    end
    chk("t3 rise count", 32'(c0), 32'd1);
    repeat (2) tick();

    // reset lands before a pending change on channel 2
    din[0] = 4'b0100;
    tick();
    rst[0] = 1'b1;
    tick();
    chk("t5 rst out", 32'(q[0]), 32'h0);
    chk("t5 rst tog", 32'(tg[0]), 32'h0);
    rst[0] = 1'b0;
    tick();
    chk("t5 r1 out", 32'(q[0]), 32'h0);
    chk("t5 r1 tog", 32'(tg[0]), 32'h0);
    tick();
    chk("t5 r2 out", 32'(q[0]), 32'h0);
    tick();
    chk("t5 r3 out", 32'(q[0]), 32'h4);
    chk("t5 r3 rise", 32'(ri[0]), 32'h4);
    din[0] = 4'h0;
    repeat (4) tick();

    // channel 3 toggling every cycle for 20 cycles
    c0 = 0; first = -1; last = -1; both = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i < 20) din[0][3] = ~din[0][3];
      tick();
      if (tg[0][3]) begin
        c0++;
        if (first < 0) first = i;
        last = i;
      end
      if (ri[0][3] && fa[0][3]) both = 1'b1;
    end
    chk("t6 toggle count", 32'(c0), 32'd20);
    chk("t6 first pulse", 32'(first), 32'd2);
    chk("t6 span", 32'(last - first + 1), 32'd20);
    chk("t6 rise&fall", 32'(both), 32'd0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
